mipi_csi_rx_lane_deskew: RTL and testbench

- Deskews the per-lane byte streams of a multi-lane MIPI CSI-2 D-PHY receiver.
- Sits between the per-lane byte/sync-detect stage and the packet decoder.
- Each lane's `bytes_valid_i` bit rises on that lane's sync byte (0xB8), possibly some cycles apart across lanes.
- Early lanes are delayed so every lane presents the same byte index in the same cycle, with a single aligned valid.

---
 rtl/mipi_csi_rx_lane_deskew.sv | 117 +++++++++++
 tb/tb_mipi_csi_rx_lane_deskew.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_csi_rx_lane_deskew.sv
`default_nettype none
// ============================================================================
// Module  : mipi_csi_rx_lane_deskew
// Brief   : Delays early CSI-2 lanes so every lane presents the same byte
//           index in the same cycle, qualified by a single aligned valid.
// Rev     : 1.0  initial release
// ============================================================================
module mipi_csi_rx_lane_deskew #(
  parameter int MIPI_GEAR   = 8,
  parameter int LANES       = 4,
  parameter int ALIGN_DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [LANES-1:0]           bytes_valid_i,
  input  logic [LANES*MIPI_GEAR-1:0] byte_i,
  output logic                       lane_valid_o,
  output logic [LANES*MIPI_GEAR-1:0] lane_byte_o
);

  localparam int              c_CW      = (ALIGN_DEPTH > 1) ? $clog2(ALIGN_DEPTH) : 1;
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(ALIGN_DEPTH - 1);

  logic                       w_all_valid;
  logic                       w_rise;
  logic                       r_prev_all_valid;
  logic [LANES-1:0]           w_sel_vld;
  logic [LANES*MIPI_GEAR-1:0] w_sel_byte;
  logic                       r_lane_valid;
  logic [LANES*MIPI_GEAR-1:0] r_lane_byte;

  assign w_all_valid = &bytes_valid_i;
  assign w_rise      = w_all_valid & ~r_prev_all_valid;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_prev_all_valid <= 1'b0;
    end else begin
      r_prev_all_valid <= w_all_valid;
    end
  end

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [MIPI_GEAR-1:0]   r_dly_byte [1:ALIGN_DEPTH-1];
      logic [ALIGN_DEPTH-1:1] r_dly_vld;
      logic [c_CW-1:0]        r_cnt;
      logic [c_CW-1:0]        r_off;
      logic [c_CW-1:0]        w_off;
      logic [MIPI_GEAR-1:0]   w_in_byte;
      logic                   w_in_vld;
      logic [MIPI_GEAR-1:0]   w_tap_byte;
      logic                   w_tap_vld;

      assign w_in_byte = byte_i[k*MIPI_GEAR +: MIPI_GEAR];
      assign w_in_vld  = bytes_valid_i[k];
      // On the alignment edge the live counts steer the taps; later cycles use the latched copy.
      assign w_off     = w_rise ? r_cnt : r_off;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          for (int n = 1; n < ALIGN_DEPTH; n++) begin
            r_dly_byte[n] <= '0;
            r_dly_vld[n]  <= 1'b0;
          end
          r_cnt <= '0;
          r_off <= '0;
        end else begin
          r_dly_byte[1] <= w_in_byte;
          r_dly_vld[1]  <= w_in_vld;
          for (int n = 2; n < ALIGN_DEPTH; n++) begin
            r_dly_byte[n] <= r_dly_byte[n-1];
            r_dly_vld[n]  <= r_dly_vld[n-1];
          end
          if (!w_in_vld) begin
            r_cnt <= '0;
          end else if (r_cnt != c_CNT_MAX) begin
            r_cnt <= r_cnt + c_CW'(1);
          end
          if (w_rise) begin
            r_off <= r_cnt;
          end
        end
      end

      always_comb begin
        w_tap_byte = w_in_byte;
        w_tap_vld  = w_in_vld;
        for (int n = 1; n < ALIGN_DEPTH; n++) begin
          if (w_off == c_CW'(n)) begin
            w_tap_byte = r_dly_byte[n];
            w_tap_vld  = r_dly_vld[n];
          end
        end
      end

      assign w_sel_byte[k*MIPI_GEAR +: MIPI_GEAR] = w_tap_byte;
      assign w_sel_vld[k]                         = w_tap_vld;
    end
  endgenerate

  // Bytes follow the taps every cycle; only the valid is gated by all lanes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lane_valid <= 1'b0;
      r_lane_byte  <= '0;
    end else begin
      r_lane_valid <= &w_sel_vld;
      r_lane_byte  <= w_sel_byte;
    end
  end

  assign lane_valid_o = r_lane_valid;
  assign lane_byte_o  = r_lane_byte;

endmodule
`default_nettype wire

// File: tb/tb_mipi_csi_rx_lane_deskew.sv
`default_nettype none
// ============================================================================
// Module  : tb_mipi_csi_rx_lane_deskew
// Brief   : Self-checking bench for the CSI-2 lane deskew block.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mipi_csi_rx_lane_deskew;

  localparam int G = 8;
  localparam int L = 4;
  localparam int D = 8;
  localparam int W = L * G;
  localparam int N = 4096;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [L-1:0] bytes_valid_i;
  logic [W-1:0] byte_i;
  logic         lane_valid_o;
  logic [W-1:0] lane_byte_o;

  always #5 clk = ~clk;

  mipi_csi_rx_lane_deskew #(
    .MIPI_GEAR   (G),
    .LANES       (L),
    .ALIGN_DEPTH (D)
  ) u_dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .bytes_valid_i (bytes_valid_i),
    .byte_i        (byte_i),
    .lane_valid_o  (lane_valid_o),
    .lane_byte_o   (lane_byte_o)
  );

  // History of applied inputs and observed outputs, indexed by clock edge.
  logic [L-1:0] hv [N];
  logic [W-1:0] hb [N];
  bit           hr [N];
  logic         ov [N];
  logic [W-1:0] ob [N];
  int           cyc    = 0;
  int           checks = 0;
  int           passed = 0;

  task automatic tick(input bit r, input logic [L-1:0] v, input logic [W-1:0] b);
    reset_i       = r;
    bytes_valid_i = v;
    byte_i        = b;
    @(posedge clk);
    hr[cyc] = r;
    hv[cyc] = v;
    hb[cyc] = b;
    #1;
    ov[cyc] = lane_valid_o;
    ob[cyc] = lane_byte_o;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, W'($urandom));
  endtask

  // Reference: find the latest all-valid rising edge since reset, derive each
  // lane's offset from its run of earlier valid cycles, then read history.
  function automatic void model(input int c, output logic ev, output logic [W-1:0] eb);
    int lastrst, r, j, n, src;
    bit found;
    int off [L];
    ev = 1'b0;
    eb = '0;
    if (hr[c]) return;
    lastrst = -1;
    for (int x = c; x >= 0; x--) if (hr[x]) begin lastrst = x; break; end
    found = 0;
    r = c;
    for (int x = c; x > lastrst; x--) begin
      if ((&hv[x]) && ((x - 1 == lastrst) || !(&hv[x-1]))) begin
        r = x; found = 1; break;
      end
    end
    for (int k = 0; k < L; k++) begin
      n = 0;
      if (found) begin
        j = r - 1;
        while (j > lastrst && hv[j][k] && n < D - 1) begin n++; j--; end
      end
      off[k] = n;
    end
    ev = 1'b1;
    for (int k = 0; k < L; k++) begin
      src = c - off[k];
      if (src <= lastrst) begin
        ev = 1'b0;
      end else begin
        eb[k*G +: G] = hb[src][k*G +: G];
        ev = ev & hv[src][k];
      end
    end
  endfunction

  function automatic logic [G-1:0] pat_byte(input int i);
    return (i == 0) ? 8'hB8 : 8'(i * 17);
  endfunction

  // Lane k is valid for len cycles starting at offset s_k; every lane carries
  // the same byte sequence, beginning with the sync byte.
  task automatic send_packet(input int s0, input int s1, input int s2, input int s3,
                             input int len, input bit fixed);
    int st [L];
    int span;
    logic [G-1:0] seq [$];
    logic [L-1:0] v;
    logic [W-1:0] b;
    st = '{s0, s1, s2, s3};
    span = 0;
    for (int k = 0; k < L; k++) if (st[k] + len > span) span = st[k] + len;
    for (int i = 0; i < len; i++) seq.push_back(fixed ? pat_byte(i) : ((i == 0) ? 8'hB8 : 8'($urandom)));
    for (int c = 0; c < span; c++) begin
      v = '0;
      b = W'($urandom);
      for (int k = 0; k < L; k++) begin
        if (c >= st[k] && c < st[k] + len) begin
          v[k] = 1'b1;
          b[k*G +: G] = seq[c - st[k]];
        end
      end
      tick(1'b0, v, b);
    end
  endtask

  task automatic test_reset;
    int c0;
    c0 = cyc;
    for (int i = 0; i < 3; i++) tick(1'b1, L'($urandom), W'($urandom));
    for (int i = 0; i < 3; i++) tick(1'b0, '0, '0);
    for (int c = c0; c < cyc; c++) begin
      checks++;
      if (ov[c] !== 1'b0 || ob[c] !== '0)
        $display("FAIL reset cyc=%0d got valid=%b byte=%h want valid=0 byte=0", c, ov[c], ob[c]);
      else passed++;
    end
  endtask

  task automatic test_skew_packet;
    int t, nv;
    logic ev;
    logic [W-1:0] eb;
    t = cyc;
    send_packet(5, 0, 4, 4, 9, 1'b1);
    idle(3);
    for (int c = t; c < cyc; c++) begin
      model(c, ev, eb);
      checks++;
      if (ov[c] !== ev || ob[c] !== eb)
        $display("FAIL skew_model cyc=%0d got %b/%h want %b/%h", c, ov[c], ob[c], ev, eb);
      else passed++;
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (ov[t+5+i] !== 1'b1 || ob[t+5+i] !== {L{pat_byte(i)}})
        $display("FAIL skew_word%0d got %b/%h want 1/%h", i, ov[t+5+i], ob[t+5+i], {L{pat_byte(i)}});
      else passed++;
    end
    nv = 0;
    for (int c = t; c < cyc; c++) if (ov[c] === 1'b1) nv++;
    checks++;
    if (nv !== 9 || ov[t+4] !== 1'b0 || ov[t+14] !== 1'b0)
      $display("FAIL staggered_end valid_count=%0d pre=%b post=%b want 9/0/0", nv, ov[t+4], ov[t+14]);
    else passed++;
  endtask

  task automatic test_second_packet;
    int s;
    logic ev;
    logic [W-1:0] eb;
    s = cyc;
    send_packet(3, 0, 2, 2, $urandom_range(4, 10), 1'b0);
    idle(2);
    for (int c = s; c < cyc; c++) begin
      model(c, ev, eb);
      checks++;
      if (ov[c] !== ev || ob[c] !== eb)
        $display("FAIL packet2_model cyc=%0d got %b/%h want %b/%h", c, ov[c], ob[c], ev, eb);
      else passed++;
    end
    checks++;
    if (ov[s+2] !== 1'b0 || ov[s+3] !== 1'b1 || ob[s+3] !== 32'hB8B8B8B8)
      $display("FAIL packet2_first got %b,%b/%h want 0,1/b8b8b8b8", ov[s+2], ov[s+3], ob[s+3]);
    else passed++;
  endtask

  task automatic test_zero_skew;
    int s, len;
    for (int p = 0; p < 3; p++) begin
      len = $urandom_range(1, 12);
      s = cyc;
      send_packet(0, 0, 0, 0, len, 1'b0);
      idle(1);
      for (int c = s; c < s + len; c++) begin
        checks++;
        if (ov[c] !== 1'b1 || ob[c] !== hb[c])
          $display("FAIL zero_skew cyc=%0d got %b/%h want 1/%h", c, ov[c], ob[c], hb[c]);
        else passed++;
      end
      checks++;
      if (ov[s+len] !== 1'b0)
        $display("FAIL zero_skew_end cyc=%0d got valid=%b want 0", s + len, ov[s+len]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int s;
    logic ev;
    logic [W-1:0] eb;
    s = cyc;
    send_packet(0, 2, 1, 0, 6, 1'b0);
    send_packet(0, 0, 3, 1, 6, 1'b0);
    send_packet(10, 0, 9, 10, 12, 1'b0);
    idle(3);
    for (int c = s; c < cyc; c++) begin
      model(c, ev, eb);
      checks++;
      if (ov[c] !== ev || ob[c] !== eb)
        $display("FAIL back_to_back cyc=%0d got %b/%h want %b/%h", c, ov[c], ob[c], ev, eb);
      else passed++;
    end
  endtask

  task automatic test_random;
    int s;
    logic ev;
    logic [W-1:0] eb;
    s = cyc;
    for (int p = 0; p < 10; p++) begin
      send_packet($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                  $urandom_range(0, 6), $urandom_range(1, 12), 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(8);
    for (int c = s; c < cyc; c++) begin
      model(c, ev, eb);
      checks++;
      if (ov[c] !== ev || ob[c] !== eb)
        $display("FAIL random cyc=%0d got %b/%h want %b/%h", c, ov[c], ob[c], ev, eb);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    int s, rc;
    int st [L];
    logic [L-1:0] v;
    logic ev;
    logic [W-1:0] eb;
    st = '{0, 3, 1, 2};
    s = cyc;
    rc = s + 6;
    for (int c = 0; c < 13; c++) begin
      v = '0;
      for (int k = 0; k < L; k++) v[k] = (c >= st[k]);
      tick(c == 6, v, W'($urandom));
    end
    idle(2);
    checks++;
    if (ov[rc] !== 1'b0 || ob[rc] !== '0)
      $display("FAIL reset_mid got %b/%h want 0/0", ov[rc], ob[rc]);
    else passed++;
    for (int c = rc + 1; c < s + 13; c++) begin
      checks++;
      if (ov[c] !== 1'b1 || ob[c] !== hb[c])
        $display("FAIL reset_mid_pass cyc=%0d got %b/%h want 1/%h", c, ov[c], ob[c], hb[c]);
      else passed++;
    end
    for (int c = s; c < cyc; c++) begin
      model(c, ev, eb);
      checks++;
      if (ov[c] !== ev || ob[c] !== eb)
        $display("FAIL reset_mid_model cyc=%0d got %b/%h want %b/%h", c, ov[c], ob[c], ev, eb);
      else passed++;
    end
  endtask

  initial begin
    reset_i       = 1'b1;
    bytes_valid_i = '0;
    byte_i        = '0;
    test_reset;
    test_skew_packet;
    test_second_packet;
    test_zero_skew;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
